// File: rtl/idli_uart_arb_m.sv
// Round-robin nibble arbiter sharing one UART TX among NUM_REQ requesters; zero-cycle req->tx path, byte = acp cycle + HI cycle.
// Backpressure: a requester holds vld until acp; optional lock (IDLI_UARB_LOCK_EN) keeps the grant across bytes.
module idli_uart_arb_m #(
  parameter int NUM_REQ = 2
) (
  input  logic                         i_uarb_gck,
  input  logic                         i_uarb_rst,
  input  logic [NUM_REQ-1:0]           i_uarb_req_vld,
  input  logic [NUM_REQ-1:0][3:0]      i_uarb_req_data,
  input  logic [NUM_REQ-1:0]           i_uarb_req_lock,
  output logic [NUM_REQ-1:0]           o_uarb_req_acp,
  output logic [NUM_REQ-1:0]           o_uarb_req_hi,
  output logic [3:0]                   o_uarb_tx,
  output logic                         o_uarb_tx_vld,
  input  logic                         i_uarb_tx_acp,
  output logic                         o_uarb_busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_uarb_gnt
);

  localparam int GNT_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_ARB    = 2'd0;
  localparam logic [1:0] S_HI     = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [GNT_W-1:0]   LAST_R = GNT_W'(NUM_REQ-1);

  logic [1:0]       r_fsm;
  logic [GNT_W-1:0] r_rr_ptr;
  logic [GNT_W-1:0] r_owner;
  logic             r_lock_q;

  logic [GNT_W-1:0] w_winner;
  logic             w_any;
  logic [GNT_W-1:0] w_sel;
  logic             w_tx_vld;
  logic             w_take;
  logic             w_lock_sel;
  logic             w_in_hi;

  // Search upward from rr_ptr with wrap; the lowest offset found last wins.
  always_comb begin
    w_winner = r_rr_ptr;
    w_any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [GNT_W-1:0] idx;
      idx = GNT_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (i_uarb_req_vld[idx]) begin
        w_winner = idx;
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel    = r_owner;
    w_tx_vld = 1'b0;
    case (r_fsm)
      S_HI:     w_sel = r_owner;
      S_LOCKED: w_tx_vld = i_uarb_req_vld[r_owner];
      default: begin
        w_sel    = w_winner;
        w_tx_vld = w_any;
      end
    endcase
  end

  assign w_in_hi = (r_fsm == S_HI);
  assign w_take  = w_tx_vld & i_uarb_tx_acp & ~i_uarb_rst;

`ifdef IDLI_UARB_LOCK_EN
  assign w_lock_sel  = i_uarb_req_lock[w_sel];
  assign o_uarb_busy = (r_fsm == S_LOCKED) | (w_in_hi & r_lock_q);
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_uarb_req_lock;
  assign w_lock_sel    = 1'b0;
  assign o_uarb_busy   = 1'b0;
`endif

  assign o_uarb_tx_vld  = w_tx_vld;
  assign o_uarb_tx      = (w_in_hi | w_tx_vld) ? i_uarb_req_data[w_sel] : 4'h0;
  assign o_uarb_req_acp = w_take ? (ONE << w_sel) : '0;
  assign o_uarb_req_hi  = w_in_hi ? (ONE << r_owner) : '0;
  assign o_uarb_gnt     = i_uarb_rst ? '0 : w_sel;

  always_ff @(posedge i_uarb_gck or posedge i_uarb_rst) begin
    if (i_uarb_rst) begin
      r_fsm    <= S_ARB;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_lock_q <= 1'b0;
    end else begin
      case (r_fsm)
        S_HI: r_fsm <= r_lock_q ? S_LOCKED : S_ARB;
        default: begin
          if (w_take) begin
            r_owner  <= w_sel;
            r_lock_q <= w_lock_sel;
            r_rr_ptr <= (w_sel == LAST_R) ? '0 : w_sel + 1'b1;
            r_fsm    <= S_HI;
          end else if ((r_fsm == S_LOCKED) && !i_uarb_req_vld[r_owner] && !w_lock_sel) begin
            r_fsm <= S_ARB;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_uart_arb_m.sv
// Bench for idli_uart_arb_m (NUM_REQ=3): directed byte scenarios plus random traffic against a transaction-level model.
module tb_idli_uart_arb_m;

  localparam int NR = 3;
`ifdef IDLI_UARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_vld = '0;
  logic [NR*4-1:0] req_data = '0;
  logic [NR-1:0]   req_lock = '0;
  logic [NR-1:0]   req_acp;
  logic [NR-1:0]   req_hi;
  logic [3:0]      tx;
  logic            tx_vld;
  logic            tx_acp = 1'b0;
  logic            busy;
  logic [1:0]      gnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: pending high nibble, current owner, next-search start, grant held by lock.
  bit m_hi   = 0;
  bit m_hold = 0;
  int m_own  = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  idli_uart_arb_m #(.NUM_REQ(NR)) dut (
    .i_uarb_gck      (clk),
    .i_uarb_rst      (rst),
    .i_uarb_req_vld  (req_vld),
    .i_uarb_req_data (req_data),
    .i_uarb_req_lock (req_lock),
    .o_uarb_req_acp  (req_acp),
    .o_uarb_req_hi   (req_hi),
    .o_uarb_tx       (tx),
    .o_uarb_tx_vld   (tx_vld),
    .i_uarb_tx_acp   (tx_acp),
    .o_uarb_busy     (busy),
    .o_uarb_gnt      (gnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [3:0] nib(input logic [NR*4-1:0] d, input int i);
    return d[i*4 +: 4];
  endfunction

  // One arbiter cycle: drive at negedge, compare outputs, advance the model to the next edge.
  task automatic step(input logic [NR-1:0] vld, input logic [NR*4-1:0] dat,
                      input logic [NR-1:0] lck, input logic acp, input logic r);
    logic [NR-1:0] e_acp, e_hi;
    logic [3:0]    e_tx;
    logic          e_vld, e_busy;
    int            e_gnt, w;
    bit            gnt_chk;
    @(negedge clk);
    req_vld = vld; req_data = dat; req_lock = lck; tx_acp = acp; rst = r;
    #1;
    if (r) begin m_hi = 0; m_hold = 0; m_own = 0; m_ptr = 0; end
    e_acp = '0; e_hi = '0; e_tx = 4'h0; e_vld = 1'b0;
    e_busy = m_hold; e_gnt = m_own; gnt_chk = 1;
    if (m_hi) begin
      e_tx = nib(dat, m_own);
      e_hi[m_own] = 1'b1;
      m_hi = 0;
    end else begin
      if (m_hold) w = vld[m_own] ? m_own : -1;
      else        w = pick(vld, m_ptr);
      e_vld = (w >= 0);
      if (w >= 0) begin
        e_tx = nib(dat, w);
        e_gnt = w;
      end else if (!m_hold) begin
        gnt_chk = 0;
      end
      if (r) begin e_gnt = 0; gnt_chk = 1; end
      if (w >= 0 && acp && !r) begin
        e_acp[w] = 1'b1;
        m_own = w;
        m_ptr = (w + 1) % NR;
        m_hold = LOCK_EN && lck[w];
        m_hi = 1;
      end else if (m_hold && w < 0 && !lck[m_own]) begin
        m_hold = 0;
      end
    end
    check_val("m_acp", req_acp, e_acp);
    check_val("m_hi", req_hi, e_hi);
    check_val("m_tx", tx, e_tx);
    check_val("m_tx_vld", tx_vld, e_vld);
    check_val("m_busy", busy, e_busy);
    if (gnt_chk) check_val("m_gnt", gnt, e_gnt);
  endtask

  initial begin
    logic [2:0] lk;
    logic [NR-1:0] wexp;

    // Reset state with no requesters.
    step(3'b000, 12'h000, 3'b000, 1'b1, 1'b1);
    check_val("rst_busy", busy, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_tx_vld", tx_vld, 0);
    check_val("rst_acp", req_acp, 0);

    // Single requester sends 0xA5.
    step(3'b001, 12'h005, 3'b000, 1'b1, 1'b0);
    check_val("a5_acp", req_acp, 3'b001);
    check_val("a5_lo", tx, 4'h5);
    step(3'b001, 12'h00A, 3'b000, 1'b0, 1'b0);
    check_val("a5_hi", req_hi, 3'b001);
    check_val("a5_hi_tx", tx, 4'hA);
    check_val("a5_hi_vld", tx_vld, 0);
    step(3'b011, 12'h037, 3'b000, 1'b0, 1'b0);
    check_val("ptr_after_a5", gnt, 1);

    // Two requesters always valid: grants alternate.
    for (int b = 0; b < 8; b++) begin
      step(3'b011, 12'($urandom), 3'b000, 1'b1, 1'b0);
      check_val("alt_acp", req_acp, 3'b001 << ((b + 1) % 2));
      step(3'b011, 12'($urandom), 3'b000, 1'b1, 1'b0);
      step(3'b011, 12'($urandom), 3'b000, 1'b0, 1'b0);
    end

    // Non-power-of-two wrap: req 2 wins from ptr 2, then ptr wraps to 0 and req 1 wins.
    step(3'b010, 12'h0C0, 3'b000, 1'b1, 1'b0);
    check_val("wrap_pre", req_acp, 3'b010);
    step(3'b010, 12'h0D0, 3'b000, 1'b0, 1'b0);
    step(3'b110, 12'h3C0, 3'b000, 1'b1, 1'b0);
    check_val("wrap_r2", req_acp, 3'b100);
    step(3'b110, 12'h4C0, 3'b000, 1'b0, 1'b0);
    step(3'b110, 12'h3C0, 3'b000, 1'b1, 1'b0);
    check_val("wrap_r1", req_acp, 3'b010);
    step(3'b110, 12'h3D0, 3'b000, 1'b0, 1'b0);

    // Req 0 sends three bytes with lock 1,1,0 while req 1 stays valid.
    lk = 3'b011;
    for (int i = 0; i < 3; i++) begin
      wexp = (!LOCK_EN && i == 1) ? 3'b010 : 3'b001;
      step(3'b011, {4'h0, 4'h7, 4'(i + 1)}, {2'b00, lk[i]}, 1'b1, 1'b0);
      check_val("lock_acp", req_acp, wexp);
      step(3'b011, {4'h0, 4'h7, 4'(i + 1)}, {2'b00, lk[i]}, 1'b0, 1'b0);
      check_val("lock_hi_busy", busy, LOCK_EN && lk[i]);
      step(3'b011, 12'h071, {2'b00, lk[i]}, 1'b0, 1'b0);
      check_val("lock_idle_busy", busy, LOCK_EN && lk[i]);
    end
    step(3'b011, 12'h071, 3'b000, 1'b1, 1'b0);
    check_val("lock_after", req_acp, 3'b010);
    step(3'b011, 12'h071, 3'b000, 1'b0, 1'b0);

    // Lock owner drops vld and lock: arbitration reopens for req 1.
    step(3'b001, 12'h009, 3'b001, 1'b1, 1'b0);
    check_val("drop_acp", req_acp, 3'b001);
    step(3'b001, 12'h009, 3'b001, 1'b0, 1'b0);
    check_val("drop_busy", busy, LOCK_EN);
    step(3'b010, 12'h050, 3'b000, 1'b0, 1'b0);
    check_val("drop_tx_vld", tx_vld, !LOCK_EN);
    step(3'b010, 12'h050, 3'b000, 1'b1, 1'b0);
    check_val("drop_r1", req_acp, 3'b010);
    step(3'b010, 12'h060, 3'b000, 1'b0, 1'b0);

    // Reset during the HI cycle.
    step(3'b001, 12'h001, 3'b001, 1'b1, 1'b0);
    step(3'b001, 12'h002, 3'b001, 1'b0, 1'b1);
    check_val("rhi_hi", req_hi, 0);
    check_val("rhi_busy", busy, 0);
    check_val("rhi_gnt", gnt, 0);
    step(3'b000, 12'h000, 3'b000, 1'b0, 1'b0);
    check_val("rhi_after_hi", req_hi, 0);
    check_val("rhi_after_vld", tx_vld, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(NR'($urandom), 12'($urandom), NR'($urandom), 1'($urandom),
           ($urandom_range(99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
